// File: rtl/cpu_step_controller.sv
// cpu_step_controller: turns monitor run/step requests into cpu_tick enables.
// Supports free-run at a programmable rate, single-clock step and
// single-instruction step, and stops ticking by itself when the CPU halts.
module cpu_step_controller #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run_req,
  input  logic                 stop_req,
  input  logic                 step_clk_req,
  input  logic                 step_inst_req,
  input  logic                 clear_count,
  input  logic [DIV_WIDTH-1:0] div_sel,
  input  logic                 dbg_F0,
  input  logic                 dbg_halt,
  output logic                 cpu_tick,
  output logic                 running,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] tick_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_TICK = 3'd1,
    RUN_WAIT = 3'd2,
    STEP_CLK = 3'd3,
    SI_TICK  = 3'd4,
    SI_WAIT  = 3'd5,
    HALTED   = 3'd6
  } state_t;

  localparam logic [DIV_WIDTH-1:0] PRESCALE_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] COUNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_reg, state_next;
  logic [DIV_WIDTH-1:0] prescaler_reg, prescaler_next;
  logic [CNT_WIDTH-1:0] tick_count_reg, tick_count_next;

  // Outputs are pure decodes of the registered state: no combinational path
  // from any input, and reset forces them low without waiting for a clock.
  assign cpu_tick   = (state_reg == RUN_TICK) || (state_reg == STEP_CLK) ||
                      (state_reg == SI_TICK);
  assign running    = (state_reg == RUN_TICK) || (state_reg == RUN_WAIT) ||
                      (state_reg == SI_TICK)  || (state_reg == SI_WAIT);
  assign halted     = (state_reg == HALTED);
  assign tick_count = tick_count_reg;

  // State and prescaler registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      prescaler_reg <= '0;
    end else begin
      state_reg     <= state_next;
      prescaler_reg <= prescaler_next;
    end
  end

  // Next-state logic. Tick states always fall into a non-tick state, and the
  // CPU flags are only looked at in non-tick states, so the one-cycle lag of
  // dbg_F0/dbg_halt behind a tick can never cause an extra tick.
  always_comb begin
    state_next     = state_reg;
    prescaler_next = prescaler_reg;
    case (state_reg)
      IDLE: begin
        if (dbg_halt) begin
          state_next = HALTED;
        end else if (stop_req) begin
          state_next = IDLE;
        end else if (run_req) begin
          state_next = RUN_TICK;
        end else if (step_inst_req) begin
          state_next = SI_TICK;
        end else if (step_clk_req) begin
          state_next = STEP_CLK;
        end
      end
      RUN_TICK: begin
        state_next     = RUN_WAIT;
        prescaler_next = '0;
      end
      RUN_WAIT: begin
        // A >= compare lets a lowered div_sel take effect immediately and
        // keeps the prescaler from ever wrapping.
        if (stop_req) begin
          state_next = IDLE;
        end else if (dbg_halt) begin
          state_next = HALTED;
        end else if (prescaler_reg >= div_sel) begin
          state_next = RUN_TICK;
        end else begin
          prescaler_next = prescaler_reg + PRESCALE_ONE;
        end
      end
      STEP_CLK: begin
        state_next = IDLE;
      end
      SI_TICK: begin
        state_next = SI_WAIT;
      end
      SI_WAIT: begin
        // The first tick of an instruction step always leaves F0, so seeing
        // F0 here means the CPU has reached the next instruction fetch.
        if (stop_req) begin
          state_next = IDLE;
        end else if (dbg_halt) begin
          state_next = HALTED;
        end else if (dbg_F0) begin
          state_next = IDLE;
        end else begin
          state_next = SI_TICK;
        end
      end
      HALTED: begin
        if (!dbg_halt) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Saturating tick counter; a clear in the same cycle as a tick wins.
  always_comb begin
    tick_count_next = tick_count_reg;
    if (clear_count) begin
      tick_count_next = '0;
    end else if (cpu_tick && (tick_count_reg != '1)) begin
      tick_count_next = tick_count_reg + COUNT_ONE;
    end
  end

  // Tick counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_count_reg <= '0;
    end else begin
      tick_count_reg <= tick_count_next;
    end
  end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed scenarios plus random requests,
// checked every cycle against a mode-level reference model and a toy CPU.
module tb_cpu_step_controller;

  localparam int DIV_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_SI   = 2;
  localparam int M_HALT = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             run_req, stop_req, step_clk_req, step_inst_req, clear_count;
  logic [DIV_W-1:0] div_sel;
  logic             dbg_F0, dbg_halt;
  logic             cpu_tick, running, halted;
  logic [CNT_W-1:0] tick_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ticks  = 0;

  // Toy CPU: an instruction is inst_len clocks; phase 0 is fetch F0.
  int cpu_phase = 0;
  int inst_len  = 4;
  bit cpu_halt  = 1'b0;

  // Reference model: operating mode, whether this cycle is a tick,
  // cycles since the last run tick, and the tick counter.
  int m_mode  = M_IDLE;
  bit m_tick  = 1'b0;
  int m_since = 0;
  int m_count = 0;

  cpu_step_controller #(.DIV_WIDTH(DIV_W), .CNT_WIDTH(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .run_req(run_req), .stop_req(stop_req), .step_clk_req(step_clk_req),
    .step_inst_req(step_inst_req), .clear_count(clear_count), .div_sel(div_sel),
    .dbg_F0(dbg_F0), .dbg_halt(dbg_halt),
    .cpu_tick(cpu_tick), .running(running), .halted(halted), .tick_count(tick_count)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_tick = 1'b0; m_since = 0; m_count = 0;
  endtask

  // Advance the model by one clock given the inputs seen during that cycle.
  task automatic model_step(input bit rr, sr, scr, sir, cc, f0, hlt, input int dsel);
    if (cc) m_count = 0;
    else if (m_tick && m_count < CNT_MAX) m_count++;
    if (m_tick) begin
      m_tick = 1'b0;
      if (m_mode == M_RUN) m_since = 1;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (hlt) m_mode = M_HALT;
          else if (!sr) begin
            if (rr) begin m_mode = M_RUN; m_tick = 1'b1; end
            else if (sir) begin m_mode = M_SI; m_tick = 1'b1; end
            else if (scr) m_tick = 1'b1;
          end
        end
        M_RUN: begin
          if (sr) m_mode = M_IDLE;
          else if (hlt) m_mode = M_HALT;
          else if (m_since > dsel) m_tick = 1'b1;
          else m_since++;
        end
        M_SI: begin
          if (sr) m_mode = M_IDLE;
          else if (hlt) m_mode = M_HALT;
          else if (f0) m_mode = M_IDLE;
          else m_tick = 1'b1;
        end
        default: begin
          if (!hlt) m_mode = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic check_outputs(input string where);
    check_val({where, "_tick"}, int'(cpu_tick), int'(m_tick));
    check_val({where, "_running"}, int'(running), int'(m_mode == M_RUN || m_mode == M_SI));
    check_val({where, "_halted"}, int'(halted), int'(m_mode == M_HALT));
    check_val({where, "_count"}, int'(tick_count), m_count);
  endtask

  // One clock: drive requests and CPU flags, clock, update CPU and model, check.
  task automatic cycle(input bit rr, sr, scr, sir, cc);
    bit prev_tick;
    run_req = rr; stop_req = sr; step_clk_req = scr; step_inst_req = sir; clear_count = cc;
    dbg_F0 = (cpu_phase == 0);
    dbg_halt = cpu_halt;
    prev_tick = cpu_tick;
    @(posedge clock);
    model_step(rr, sr, scr, sir, cc, dbg_F0, dbg_halt, int'(div_sel));
    if (prev_tick) cpu_phase = (cpu_phase + 1) % inst_len;
    #1;
    check_outputs("cyc");
    if (cpu_tick) n_ticks++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    int base;
    int guard;
    reset = 1'b0;
    run_req = 0; stop_req = 0; step_clk_req = 0; step_inst_req = 0; clear_count = 0;
    div_sel = '0; dbg_F0 = 1'b1; dbg_halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    #1 reset = 1'b1;

    // 1: three single-clock steps
    base = n_ticks;
    for (int i = 0; i < 3; i++) begin cycle(0, 0, 1, 0, 0); idle(3); end
    check_val("t1_ticks", n_ticks - base, 3);
    check_val("t1_count", int'(tick_count), 3);
    $display("t1 step_clk x3: ticks=%0d count=%0d", n_ticks - base, tick_count);

    // 2: free run at div 0 (period 2), then div 3 (period 5)
    cycle(0, 0, 0, 0, 1);
    div_sel = 8'd0;
    base = n_ticks;
    cycle(1, 0, 0, 0, 0);
    idle(19);
    check_val("t2_div0_ticks", n_ticks - base, 10);
    base = n_ticks;
    cycle(0, 1, 0, 0, 0);
    idle(5);
    check_val("t2_after_stop", n_ticks - base, 0);
    $display("t2 div0 run: stopped, ticks after stop=%0d", n_ticks - base);
    div_sel = 8'd3;
    base = n_ticks;
    cycle(1, 0, 0, 0, 0);
    idle(19);
    check_val("t2_div3_ticks", n_ticks - base, 4);
    cycle(0, 1, 0, 0, 0);
    idle(2);
    $display("t2 div3 run: ticks in 20 cycles=%0d", n_ticks - base);

    // 3: instruction step with a 4-clock instruction, starting at F0
    inst_len = 4; cpu_phase = 0;
    base = n_ticks;
    cycle(0, 0, 0, 1, 0);
    check_val("t3_running_during", int'(running), 1);
    idle(10);
    check_val("t3_ticks", n_ticks - base, 4);
    check_val("t3_at_fetch", int'(cpu_phase == 0), 1);
    check_val("t3_running_after", int'(running), 0);
    $display("t3 step_inst: ticks=%0d phase=%0d", n_ticks - base, cpu_phase);

    // 4: halt raised after the 7th run tick
    div_sel = 8'd0;
    base = n_ticks;
    cycle(1, 0, 0, 0, 0);
    guard = 0;
    while ((n_ticks - base) < 7 && guard < 60) begin idle(1); guard++; end
    cpu_halt = 1'b1;
    idle(4);
    check_val("t4_ticks", n_ticks - base, 7);
    check_val("t4_halted", int'(halted), 1);
    base = n_ticks;
    cycle(1, 0, 0, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 0, 1, 0); idle(2);
    check_val("t4_ignored", n_ticks - base, 0);
    cpu_halt = 1'b0;
    idle(2);
    check_val("t4_released", int'(halted), 0);
    $display("t4 halt: halted cleared, ignored ticks=%0d", n_ticks - base);

    // 5: saturation at 15, then clear coincident with a tick
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    idle(40);
    check_val("t5_saturated", int'(tick_count), CNT_MAX);
    guard = 0;
    while (cpu_tick !== 1'b1 && guard < 10) begin idle(1); guard++; end
    cycle(0, 0, 0, 0, 1);
    check_val("t5_clear_on_tick", int'(tick_count), 0);
    cycle(0, 1, 0, 0, 0);
    idle(2);
    $display("t5 saturation: cleared count=%0d", tick_count);

    // 6: run wins over step_clk; async reset in the middle of a run tick
    cycle(1, 0, 1, 0, 0);
    check_val("t6_run_wins", int'(running), 1);
    idle(1);
    guard = 0;
    while (cpu_tick !== 1'b1 && guard < 10) begin idle(1); guard++; end
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_async");
    @(posedge clock); #1;
    check_outputs("t6_held");
    #2 reset = 1'b1;
    $display("t6 async reset: tick=%0d count=%0d", cpu_tick, tick_count);

    // Random requests, rate changes and halts against the model.
    inst_len = 3; cpu_phase = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) div_sel = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) cpu_halt = ~cpu_halt;
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0);
    end
    $display("random phase: %0d ticks total", n_ticks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
